fft_seq_core: RTL and testbench

Parametrised sequential radix-2 DIT FFT core, successor to the fixed 8-point combinational FFT in this codebase. Accepts one complex frame of N = 2^LOG2N samples over a valid/ready stream, computes the transform in place with a single time-shared butterfly, and streams the N bins out in natural order. Adds selectable N, data width, per-frame per-stage scaling and backpressure.

---
 rtl/fft_seq_if.sv | 44 ++++
 rtl/fft_seq_core.sv | 205 ++++++++++++++++++++
 tb/tb_fft_seq_core.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fft_seq_if.sv
// ----------------------------------------------------------------------------
// fft_seq_if
// Stream bundle between an FFT frame source/sink and fft_seq_core.
//
// Handshake rule (both directions): a transfer happens on a rising clk edge
// where valid and ready are both 1. While valid=1 and ready=0, the producer
// holds its data (and out_last) unchanged. Ready never depends
// combinationally on valid.
//
// Signals
//   in_valid / in_ready        input sample handshake
//   in_real / in_imag          input sample, signed DATA_W each
//   in_scale                   taken with the first sample of a frame
//   out_valid / out_ready      output bin handshake
//   out_real / out_imag        output bin, signed DATA_W each
//   out_last                   marks bin N-1
//   busy                       core is transforming or unloading
// Modports: master = frame source/sink (testbench), slave = core.
// ----------------------------------------------------------------------------
interface fft_seq_if #(
  parameter int DATA_W = 16
);
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] in_real;
  logic signed [DATA_W-1:0] in_imag;
  logic                     in_scale;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [DATA_W-1:0] out_real;
  logic signed [DATA_W-1:0] out_imag;
  logic                     out_last;
  logic                     busy;

  modport master (
    output in_valid, in_real, in_imag, in_scale, out_ready,
    input  in_ready, out_valid, out_real, out_imag, out_last, busy
  );

  modport slave (
    input  in_valid, in_real, in_imag, in_scale, out_ready,
    output in_ready, out_valid, out_real, out_imag, out_last, busy
  );
endinterface

// File: rtl/fft_seq_core.sv
// ----------------------------------------------------------------------------
// fft_seq_core
// Sequential radix-2 DIT FFT of N = 2^LOG2N complex samples. Samples are
// loaded in bit-reversed order into an N-entry register array, transformed
// in place by one time-shared butterfly (one butterfly per cycle), and
// streamed out in natural order.
//
// Ports
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset
//   bus          fft_seq_if.slave stream bundle (see interface header)
//   dbg_state_o  FSM state: 0 = LOAD, 1 = CALC, 2 = UNLOAD
// Parameters
//   DATA_W  component width (signed), LOG2N  2..4
// ----------------------------------------------------------------------------
module fft_seq_core #(
  parameter int DATA_W = 16,
  parameter int LOG2N  = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  fft_seq_if.slave   bus,
  output logic [1:0] dbg_state_o
);
  localparam int N  = 1 << LOG2N;
  localparam int PW = DATA_W + 11;  // product width: DATA_W x 10-bit twiddle, plus sum

  generate
    if (LOG2N < 2 || LOG2N > 4) begin : g_bad_log2n
      $error("fft_seq_core: LOG2N must be 2..4");
    end
  endgenerate

  typedef enum logic [1:0] {LOAD = 2'd0, CALC = 2'd1, UNLOAD = 2'd2} state_t;

  localparam logic [LOG2N-1:0] CNT_LAST   = LOG2N'(N - 1);
  localparam logic [LOG2N-2:0] BFLY_LAST  = '1;
  localparam logic [1:0]       STAGE_LAST = 2'(LOG2N - 1);

  state_t                   state_q;
  logic signed [DATA_W-1:0] mem_re_q [N];
  logic signed [DATA_W-1:0] mem_im_q [N];
  logic [LOG2N-1:0]         cnt_q;    // sample index in LOAD, bin index in UNLOAD
  logic [LOG2N-2:0]         bfly_q;   // butterfly within stage
  logic [1:0]               stage_q;
  logic                     scale_q;
  logic                     in_ready_q, busy_q, out_valid_q, out_last_q;
  logic signed [DATA_W-1:0] out_re_q, out_im_q;

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] v);
    logic [LOG2N-1:0] r;
    for (int i = 0; i < LOG2N; i++) r[i] = v[LOG2N-1-i];
    return r;
  endfunction

  // Only the first half of the 16-point table is ever addressed by a DIT
  // butterfly, so indices 0..7 cover every legal N.
  function automatic logic signed [9:0] tw_re(input logic [2:0] i);
    case (i)
      3'd0: return 10'sd256;
      3'd1: return 10'sd237;
      3'd2: return 10'sd181;
      3'd3: return 10'sd98;
      3'd4: return 10'sd0;
      3'd5: return -10'sd98;
      3'd6: return -10'sd181;
      default: return -10'sd237;
    endcase
  endfunction

  function automatic logic signed [9:0] tw_im(input logic [2:0] i);
    case (i)
      3'd0: return 10'sd0;
      3'd1: return 10'sd98;
      3'd2: return 10'sd181;
      3'd3: return 10'sd237;
      3'd4: return 10'sd256;
      3'd5: return 10'sd237;
      3'd6: return 10'sd181;
      default: return 10'sd98;
    endcase
  endfunction

  // Butterfly addressing and datapath
  int                       b_i, s_i, pos_i, top_i;
  logic [LOG2N-1:0]         top_a, bot_a, cnt_nxt;
  logic [2:0]               tw_a;
  logic signed [9:0]        wr, ws;
  logic signed [DATA_W-1:0] a_re, a_im, b_re, b_im, t_re, t_im;
  logic signed [PW-1:0]     p_re, p_im;
  logic signed [DATA_W:0]   s_re, s_im, d_re, d_im;
  logic signed [DATA_W-1:0] x_top_re, x_top_im, x_bot_re, x_bot_im;

  always_comb begin
    b_i   = int'(bfly_q);
    s_i   = int'(stage_q);
    pos_i = b_i & ((1 << s_i) - 1);
    top_i = ((b_i >> s_i) << (s_i + 1)) + pos_i;
    top_a = LOG2N'(top_i);
    bot_a = LOG2N'(top_i + (1 << s_i));
    // pos << (LOG2N-1-s) scaled to the 16-entry table by << (4-LOG2N)
    tw_a  = 3'(pos_i << (3 - s_i));
    wr    = tw_re(tw_a);
    ws    = tw_im(tw_a);
    a_re  = mem_re_q[top_a];
    a_im  = mem_im_q[top_a];
    b_re  = mem_re_q[bot_a];
    b_im  = mem_im_q[bot_a];
    p_re  = PW'(b_re) * PW'(wr) + PW'(b_im) * PW'(ws);
    p_im  = PW'(b_im) * PW'(wr) - PW'(b_re) * PW'(ws);
    t_re  = DATA_W'(p_re >>> 8);
    t_im  = DATA_W'(p_im >>> 8);
    // One extra bit so the optional halving is exact before wrapping.
    s_re  = (DATA_W+1)'(a_re) + (DATA_W+1)'(t_re);
    s_im  = (DATA_W+1)'(a_im) + (DATA_W+1)'(t_im);
    d_re  = (DATA_W+1)'(a_re) - (DATA_W+1)'(t_re);
    d_im  = (DATA_W+1)'(a_im) - (DATA_W+1)'(t_im);
    x_top_re = scale_q ? s_re[DATA_W:1] : s_re[DATA_W-1:0];
    x_top_im = scale_q ? s_im[DATA_W:1] : s_im[DATA_W-1:0];
    x_bot_re = scale_q ? d_re[DATA_W:1] : d_re[DATA_W-1:0];
    x_bot_im = scale_q ? d_im[DATA_W:1] : d_im[DATA_W-1:0];
    cnt_nxt  = cnt_q + LOG2N'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= LOAD;
      cnt_q       <= '0;
      bfly_q      <= '0;
      stage_q     <= '0;
      scale_q     <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_re_q    <= '0;
      out_im_q    <= '0;
    end else begin
      unique case (state_q)
        LOAD: begin
          if (bus.in_valid && in_ready_q) begin
            mem_re_q[bitrev(cnt_q)] <= bus.in_real;
            mem_im_q[bitrev(cnt_q)] <= bus.in_imag;
            if (cnt_q == '0) scale_q <= bus.in_scale;
            cnt_q <= cnt_nxt;  // wraps to 0 after the last sample
            if (cnt_q == CNT_LAST) begin
              state_q    <= CALC;
              in_ready_q <= 1'b0;
              busy_q     <= 1'b1;
            end
          end
        end
        CALC: begin
          mem_re_q[top_a] <= x_top_re;
          mem_im_q[top_a] <= x_top_im;
          mem_re_q[bot_a] <= x_bot_re;
          mem_im_q[bot_a] <= x_bot_im;
          if (bfly_q == BFLY_LAST) begin
            bfly_q <= '0;
            if (stage_q == STAGE_LAST) begin
              stage_q     <= '0;
              state_q     <= UNLOAD;
              out_valid_q <= 1'b1;
              out_last_q  <= 1'b0;
              // Bin 0 is finished by butterfly 0 of the last stage, long
              // before this final butterfly, so it can be read now.
              out_re_q    <= mem_re_q[0];
              out_im_q    <= mem_im_q[0];
            end else begin
              stage_q <= stage_q + 2'd1;
            end
          end else begin
            bfly_q <= bfly_q + 1'b1;
          end
        end
        UNLOAD: begin
          if (bus.out_ready) begin
            if (cnt_q == CNT_LAST) begin
              state_q     <= LOAD;
              cnt_q       <= '0;
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              in_ready_q  <= 1'b1;
              busy_q      <= 1'b0;
            end else begin
              cnt_q      <= cnt_nxt;
              out_re_q   <= mem_re_q[cnt_nxt];
              out_im_q   <= mem_im_q[cnt_nxt];
              out_last_q <= (cnt_nxt == CNT_LAST);
            end
          end
        end
        default: state_q <= LOAD;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.busy      = busy_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_real  = out_re_q;
  assign bus.out_imag  = out_im_q;
  assign dbg_state_o   = state_q;
endmodule

// File: tb/tb_fft_seq_core.sv
module tb_fft_seq_core;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Shared drive, steered to the instance selected by sel (4, 8 or 16 points)
  int                 sel;
  logic               in_valid, in_scale, out_ready;
  logic signed [15:0] in_real, in_imag;
  logic               o_in_ready, o_valid, o_last, o_busy;
  logic signed [15:0] o_real, o_imag;
  logic [1:0]         dbg4, dbg8, dbg16;

  fft_seq_if #(.DATA_W(16)) if4 ();
  fft_seq_if #(.DATA_W(16)) if8 ();
  fft_seq_if #(.DATA_W(16)) if16 ();

  fft_seq_core #(.DATA_W(16), .LOG2N(2)) u4  (.clk(clk), .rst_n(rst_n), .bus(if4.slave),  .dbg_state_o(dbg4));
  fft_seq_core #(.DATA_W(16), .LOG2N(3)) u8  (.clk(clk), .rst_n(rst_n), .bus(if8.slave),  .dbg_state_o(dbg8));
  fft_seq_core #(.DATA_W(16), .LOG2N(4)) u16 (.clk(clk), .rst_n(rst_n), .bus(if16.slave), .dbg_state_o(dbg16));

  assign if4.in_valid   = in_valid && (sel == 4);
  assign if8.in_valid   = in_valid && (sel == 8);
  assign if16.in_valid  = in_valid && (sel == 16);
  assign if4.out_ready  = out_ready && (sel == 4);
  assign if8.out_ready  = out_ready && (sel == 8);
  assign if16.out_ready = out_ready && (sel == 16);
  assign if4.in_real  = in_real;  assign if4.in_imag  = in_imag;  assign if4.in_scale  = in_scale;
  assign if8.in_real  = in_real;  assign if8.in_imag  = in_imag;  assign if8.in_scale  = in_scale;
  assign if16.in_real = in_real;  assign if16.in_imag = in_imag;  assign if16.in_scale = in_scale;

  always_comb begin
    o_in_ready = if8.in_ready; o_valid = if8.out_valid; o_last = if8.out_last;
    o_busy = if8.busy; o_real = if8.out_real; o_imag = if8.out_imag;
    if (sel == 4) begin
      o_in_ready = if4.in_ready; o_valid = if4.out_valid; o_last = if4.out_last;
      o_busy = if4.busy; o_real = if4.out_real; o_imag = if4.out_imag;
    end else if (sel == 16) begin
      o_in_ready = if16.in_ready; o_valid = if16.out_valid; o_last = if16.out_last;
      o_busy = if16.busy; o_real = if16.out_real; o_imag = if16.out_imag;
    end
  end

  // Scoreboard
  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_q[$];   // {re, im} of each expected bin, in order
  int          in_re[16];
  int          in_im[16];
  int          wr_t[8] = '{256, 237, 181, 98, 0, -98, -181, -237};
  int          ws_t[8] = '{0, 98, 181, 237, 256, 237, 181, 98};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    total++;
    assert (obs === req) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, req);
    end
  endtask

  task automatic push(input int re, input int im);
    exp_q.push_back({16'(re), 16'(im)});
  endtask

  function automatic longint wrap16(input longint v);
    shortint t;
    t = shortint'(v);
    return longint'(t);
  endfunction

  // Textbook in-place DIT: group / position loops, W_{2h}^p taken from the
  // 16-point table at index p*16/(2h), fixed-point rules applied per butterfly.
  task automatic model_push(input int lg, input bit sc);
    int n, h, w, r, u, v;
    longint re[16];
    longint im[16];
    longint tr, ti, sr, si, dr, di;
    n = 1 << lg;
    for (int k = 0; k < n; k++) begin
      r = 0;
      for (int i = 0; i < lg; i++) if (k[i]) r |= 1 << (lg - 1 - i);
      re[r] = in_re[k];
      im[r] = in_im[k];
    end
    for (int s = 0; s < lg; s++) begin
      h = 1 << s;
      for (int g = 0; g < n; g += 2 * h) begin
        for (int p = 0; p < h; p++) begin
          w = p * 16 / (2 * h);
          u = g + p;
          v = g + p + h;
          tr = wrap16((re[v] * wr_t[w] + im[v] * ws_t[w]) >>> 8);
          ti = wrap16((im[v] * wr_t[w] - re[v] * ws_t[w]) >>> 8);
          sr = re[u] + tr; si = im[u] + ti;
          dr = re[u] - tr; di = im[u] - ti;
          if (sc) begin sr = sr >>> 1; si = si >>> 1; dr = dr >>> 1; di = di >>> 1; end
          re[u] = wrap16(sr); im[u] = wrap16(si);
          re[v] = wrap16(dr); im[v] = wrap16(di);
        end
      end
    end
    for (int j = 0; j < n; j++) push(int'(re[j]), int'(im[j]));
  endtask

  task automatic clear_in();
    for (int k = 0; k < 16; k++) begin in_re[k] = 0; in_im[k] = 0; end
  endtask

  task automatic rand_in(input int amp);
    for (int k = 0; k < 16; k++) begin
      if (amp == 0) begin
        in_re[k] = int'($signed(16'($urandom)));
        in_im[k] = int'($signed(16'($urandom)));
      end else begin
        in_re[k] = $urandom_range(0, 2 * amp) - amp;
        in_im[k] = $urandom_range(0, 2 * amp) - amp;
      end
    end
  endtask

  // Drive one frame; returns right after the posedge that accepts the last sample.
  task automatic send_frame(input int lg, input bit sc, input int gap_pct);
    int n, k, cyc;
    n = 1 << lg; k = 0; cyc = 0;
    while (k < n && cyc < 1000) begin
      @(negedge clk); cyc++;
      if ($urandom_range(0, 99) < gap_pct) begin
        in_valid = 1'b0;
        in_real = 16'($urandom); in_imag = 16'($urandom); in_scale = 1'($urandom);
      end else begin
        chk("in_ready_load", 32'(o_in_ready), 32'd1);
        in_valid = 1'b1;
        in_real = 16'(in_re[k]); in_imag = 16'(in_im[k]);
        in_scale = (k == 0) ? sc : ~sc;  // only the first sample's flag may count
        @(posedge clk);
        k++;
      end
    end
    chk("send_timeout", 32'(k), 32'(n));
  endtask

  // Collect N bins against exp_q, checking latency, hold-while-stalled and out_last.
  task automatic collect(input int lg, input int ready_pct);
    int n, j, cyc;
    bit stalled, seen, held_last;
    logic [31:0] held, req;
    n = 1 << lg; j = 0; cyc = 0; stalled = 0; seen = 0; held = '0; held_last = 0;
    while (j < n && cyc < 3000) begin
      @(negedge clk); cyc++;
      in_valid = 1'($urandom);  // must be ignored while the core is busy
      in_real = 16'($urandom); in_imag = 16'($urandom); in_scale = 1'($urandom);
      if (stalled) begin
        chk("hold_data", {o_real, o_imag}, held);
        chk("hold_last", 32'(o_last), 32'(held_last));
        chk("hold_valid", 32'(o_valid), 32'd1);
      end
      if (!seen) begin
        if (o_valid) begin
          seen = 1;
          chk("latency", 32'(cyc), 32'(lg * n / 2 + 1));
        end else if (cyc == 1) begin
          chk("busy_calc", 32'(o_busy), 32'd1);
          chk("in_ready_calc", 32'(o_in_ready), 32'd0);
        end
      end
      out_ready = ($urandom_range(0, 99) < ready_pct);
      stalled = 0;
      if (o_valid) begin
        chk("in_ready_unload", 32'(o_in_ready), 32'd0);
        if (out_ready) begin
          req = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxxxxxx;
          chk($sformatf("bin%0d_n%0d", j, n), {o_real, o_imag}, req);
          chk("out_last", 32'(o_last), 32'(j == n - 1));
          j++;
        end else begin
          stalled = 1; held = {o_real, o_imag}; held_last = o_last;
        end
      end
    end
    chk("collect_timeout", 32'(j), 32'(n));
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    chk("in_ready_after", 32'(o_in_ready), 32'd1);
    chk("busy_after", 32'(o_busy), 32'd0);
    chk("valid_after", 32'(o_valid), 32'd0);
  endtask

  initial begin
    bit sc;
    rst_n = 1'b0; in_valid = 1'b0; in_real = '0; in_imag = '0; in_scale = 1'b0;
    out_ready = 1'b0; sel = 8;
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    #1;

    // Reset state on every build
    for (int i = 0; i < 3; i++) begin
      sel = 4 << i;
      #1;
      chk("rst_in_ready", 32'(o_in_ready), 32'd1);
      chk("rst_out_valid", 32'(o_valid), 32'd0);
      chk("rst_out_last", 32'(o_last), 32'd0);
      chk("rst_busy", 32'(o_busy), 32'd0);
      chk("rst_out_data", {o_real, o_imag}, 32'd0);
    end
    chk("rst_dbg", {26'd0, dbg4, dbg8, dbg16}, 32'd0);
    sel = 8;

    // Impulse: every bin equals x0
    clear_in(); in_re[0] = 100; exp_q.delete();
    repeat (8) push(100, 0);
    send_frame(3, 1'b0, 0); collect(3, 100);

    // DC, unscaled and scaled
    for (int k = 0; k < 8; k++) in_re[k] = 100;
    exp_q.delete(); push(800, 0); repeat (7) push(0, 0);
    send_frame(3, 1'b0, 0); collect(3, 100);
    exp_q.delete(); push(100, 0); repeat (7) push(0, 0);
    send_frame(3, 1'b1, 0); collect(3, 100);

    // Single tone at x1
    clear_in(); in_re[1] = 256; exp_q.delete();
    push(256, 0); push(181, -181); push(0, -256); push(-181, -181);
    push(-256, 0); push(-181, 181); push(0, 256); push(181, 181);
    send_frame(3, 1'b0, 0); collect(3, 100);

    // Alternating sign on the 16- and 4-point builds
    for (int i = 0; i < 2; i++) begin
      sel = (i == 0) ? 16 : 4;
      clear_in();
      for (int k = 0; k < sel; k++) in_re[k] = (k % 2) ? -64 : 64;
      exp_q.delete();
      for (int k = 0; k < sel; k++) push((k == sel / 2) ? 64 * sel : 0, 0);
      send_frame((i == 0) ? 4 : 2, 1'b0, 0); collect((i == 0) ? 4 : 2, 100);
    end

    // Random frames: free-running, then same data with gaps and backpressure
    sel = 8;
    for (int f = 0; f < 3; f++) begin
      rand_in((f == 0) ? 0 : 3000);
      sc = 1'($urandom);
      exp_q.delete(); model_push(3, sc);
      send_frame(3, sc, 0); collect(3, 100);
      exp_q.delete(); model_push(3, sc);
      send_frame(3, sc, 40); collect(3, 30);
    end
    for (int i = 0; i < 2; i++) begin
      sel = (i == 0) ? 16 : 4;
      rand_in(0);
      sc = 1'($urandom);
      exp_q.delete(); model_push((i == 0) ? 4 : 2, sc);
      send_frame((i == 0) ? 4 : 2, sc, 30); collect((i == 0) ? 4 : 2, 30);
    end

    // Reset pulse in the middle of CALC abandons the frame
    sel = 8;
    rand_in(1000); exp_q.delete();
    send_frame(3, 1'b0, 0);
    @(negedge clk); in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("busy_mid_calc", 32'(o_busy), 32'd1);
    chk("dbg_mid_calc", 32'(dbg8), 32'd1);
    rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    chk("rst_mid_valid", 32'(o_valid), 32'd0);
    chk("rst_mid_busy", 32'(o_busy), 32'd0);
    chk("rst_mid_in_ready", 32'(o_in_ready), 32'd1);
    repeat (5) begin
      @(negedge clk);
      chk("rst_no_output", 32'(o_valid), 32'd0);
    end
    clear_in(); in_re[0] = -77; in_im[0] = 33; exp_q.delete();
    repeat (8) push(-77, 33);
    send_frame(3, 1'b0, 0); collect(3, 100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
